opl3_timer_ctrl: RTL and testbench



---
 rtl/opl3_timer_ctrl_if.sv | 29 ++
 rtl/opl3_timer_ctrl.sv | 162 ++++++++++++++++
 tb/tb_opl3_timer_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/opl3_timer_ctrl_if.sv
// rtl/opl3_timer_ctrl_if.sv - host-side bus for the OPL3 timer controller
// Purpose: bundles the pre-decoded register write strobes, write data and
//          the status/interrupt outputs between the host decoder and the timers.
// Signals:
//   tl1_wr  : write wdata to timer-1 load register
//   tl2_wr  : write wdata to timer-2 load register
//   ctrl_wr : write wdata to control register
//   wdata   : 8-bit host write data
//   status  : {IRQ, FT1, FT2, 5'b0}
//   irq_n   : active-low interrupt
// Modports: master = host decoder, slave = timer controller.
interface opl3_timer_ctrl_if;
  logic       tl1_wr;
  logic       tl2_wr;
  logic       ctrl_wr;
  logic [7:0] wdata;
  logic [7:0] status;
  logic       irq_n;

  modport master (
    output tl1_wr, tl2_wr, ctrl_wr, wdata,
    input  status, irq_n
  );

  modport slave (
    input  tl1_wr, tl2_wr, ctrl_wr, wdata,
    output status, irq_n
  );
endinterface

// File: rtl/opl3_timer_ctrl.sv
// rtl/opl3_timer_ctrl.sv - OPL3 host timers, overflow flags, status byte and IRQ
// Purpose: two 8-bit up-counting host timers clocked from a shared clk_en
//          prescaler chain (tick1 every TICK1_DIV clk_en, tick2 every TICK2_DIV
//          tick1), with start/mask control, overflow flags and interrupt.
// Ports:
//   i_clk    : system clock
//   i_reset  : synchronous active-high reset
//   i_clk_en : sample-rate strobe, one clock wide
//   io_bus   : opl3_timer_ctrl_if.slave (write strobes, wdata, status, irq_n)
// Configuration macro: OPL3_TIMER_IRQ_EN
//   defined   -> irq_n = ~(FT1 | FT2)
//   undefined -> irq_n tied high (polled operation, status unchanged)
module opl3_timer_ctrl #(
  parameter int TICK1_DIV = 4,
  parameter int TICK2_DIV = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clk_en,
  opl3_timer_ctrl_if.slave   io_bus
);

  localparam int P1W = (TICK1_DIV > 1) ? $clog2(TICK1_DIV) : 1;
  localparam int P2W = (TICK2_DIV > 1) ? $clog2(TICK2_DIV) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  logic [P1W-1:0] r_pre1;
  logic [P2W-1:0] r_pre2;
  logic           w_tick1;
  logic           w_tick2;

  state_t         r_state    [2];
  state_t         w_state_nx [2];
  logic [7:0]     r_cnt      [2];
  logic [7:0]     r_tl       [2];
  logic [1:0]     r_mt;
  logic [1:0]     r_ft;

  logic [1:0]     w_tick;
  logic [1:0]     w_run;
  logic [1:0]     w_start;
  logic [1:0]     w_ovf;
  logic [1:0]     w_st_bit;
  logic [1:0]     w_mt_bit;
  logic           w_ctrl_apply;
  logic           w_irq;
  logic           w_unused;

  // Prescaler chain: free-running from reset, never touched by host writes.
  assign w_tick1 = i_clk_en & (r_pre1 == P1W'(TICK1_DIV - 1));
  assign w_tick2 = w_tick1 & (r_pre2 == P2W'(TICK2_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pre1 <= '0;
      r_pre2 <= '0;
    end else if (i_clk_en) begin
      r_pre1 <= w_tick1 ? '0 : r_pre1 + 1'b1;
      if (w_tick1) begin
        r_pre2 <= w_tick2 ? '0 : r_pre2 + 1'b1;
      end
    end
  end

  // Index 0 is timer 1, index 1 is timer 2. RST=1 makes the write touch
  // only the flags, so MT/ST updates are gated on RST=0.
  assign w_tick       = {w_tick2, w_tick1};
  assign w_ctrl_apply = io_bus.ctrl_wr & ~io_bus.wdata[7];
  assign w_st_bit     = {io_bus.wdata[1], io_bus.wdata[0]};
  assign w_mt_bit     = {io_bus.wdata[5], io_bus.wdata[6]};

  // Timer FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 2; i++) r_state[i] <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Timer FSM: next state
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nx[i] = r_state[i];
      if (w_ctrl_apply) begin
        w_state_nx[i] = w_st_bit[i] ? S_RUN : S_IDLE;
      end
    end
  end

  // Timer FSM: outputs. A start only happens from IDLE, so a coincident
  // tick is never counted on the reload cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_run[i]   = (r_state[i] == S_RUN);
      w_start[i] = w_ctrl_apply & w_st_bit[i] & ~w_run[i];
      w_ovf[i]   = w_run[i] & w_tick[i] & (r_cnt[i] == 8'hFF);
    end
  end

  // Counters reload from the pre-write r_tl, so a load write coinciding
  // with a reload only affects the following period.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 2; i++) r_cnt[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_start[i] || w_ovf[i]) begin
          r_cnt[i] <= r_tl[i];
        end else if (w_run[i] && w_tick[i]) begin
          r_cnt[i] <= r_cnt[i] + 8'h01;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tl[0] <= 8'h00;
      r_tl[1] <= 8'h00;
    end else begin
      if (io_bus.tl1_wr) r_tl[0] <= io_bus.wdata;
      if (io_bus.tl2_wr) r_tl[1] <= io_bus.wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mt <= 2'b00;
    end else if (w_ctrl_apply) begin
      r_mt <= w_mt_bit;
    end
  end

  // Overflow set has priority over both RST clear and mask clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ft <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_ovf[i] && !r_mt[i]) begin
          r_ft[i] <= 1'b1;
        end else if (io_bus.ctrl_wr && (io_bus.wdata[7] || w_mt_bit[i])) begin
          r_ft[i] <= 1'b0;
        end
      end
    end
  end

  assign w_irq         = r_ft[0] | r_ft[1];
  assign io_bus.status = {w_irq, r_ft[0], r_ft[1], 5'b0_0000};

`ifdef OPL3_TIMER_IRQ_EN
  assign io_bus.irq_n = ~w_irq;
`else
  assign io_bus.irq_n = 1'b1;
`endif

  assign w_unused = &{1'b0, io_bus.wdata[4:2]};

endmodule

// File: tb/tb_opl3_timer_ctrl.sv
// tb/tb_opl3_timer_ctrl.sv - self-checking bench for opl3_timer_ctrl
module tb_opl3_timer_ctrl;

  logic clk;
  logic reset;
  logic clk_en;

  opl3_timer_ctrl_if bus_if ();

  opl3_timer_ctrl #(.TICK1_DIV(4), .TICK2_DIV(4)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clk_en (clk_en),
    .io_bus   (bus_if)
  );

`ifdef OPL3_TIMER_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  typedef struct {
    bit         rst;
    bit         t1;
    bit         t2;
    bit         c;
    logic [7:0] d;
    int         n_en;
    logic [7:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit en, input bit t1, input bit t2, input bit c, input logic [7:0] d);
    clk_en         = en;
    bus_if.tl1_wr  = t1;
    bus_if.tl2_wr  = t2;
    bus_if.ctrl_wr = c;
    bus_if.wdata   = d;
    @(posedge clk);
    #1;
    clk_en         = 1'b0;
    bus_if.tl1_wr  = 1'b0;
    bus_if.tl2_wr  = 1'b0;
    bus_if.ctrl_wr = 1'b0;
    bus_if.wdata   = 8'h00;
  endtask

  task automatic pulse_en(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] exp_status);
    logic exp_irq_n;
    exp_irq_n = IRQ_EN ? ~exp_status[7] : 1'b1;
    n_checks++;
    if (bus_if.status !== exp_status) begin
      n_errors++;
      $display("FAIL %s status: got %02h expected %02h", name, bus_if.status, exp_status);
    end
    n_checks++;
    if (bus_if.irq_n !== exp_irq_n) begin
      n_errors++;
      $display("FAIL %s irq_n: got %b expected %b", name, bus_if.irq_n, exp_irq_n);
    end
  endtask

  vec_t vecs[$];

  initial begin
    reset          = 1'b1;
    clk_en         = 1'b0;
    bus_if.tl1_wr  = 1'b0;
    bus_if.tl2_wr  = 1'b0;
    bus_if.ctrl_wr = 1'b0;
    bus_if.wdata   = 8'h00;

    //             rst t1 t2 c  data   n_en  status
    vecs.push_back('{1, 0, 0, 0, 8'h00, 0,    8'h00}); // 0 reset
    vecs.push_back('{0, 0, 0, 0, 8'h00, 1000, 8'h00}); // 1 idle 1000 clk_en
    vecs.push_back('{1, 1, 0, 0, 8'hFE, 0,    8'h00}); // 2 TL1=FE
    vecs.push_back('{0, 0, 0, 1, 8'h01, 7,    8'h00}); // 3 start T1, 7 clk_en
    vecs.push_back('{0, 0, 0, 0, 8'h00, 1,    8'hC0}); // 4 8th clk_en -> FT1
    vecs.push_back('{0, 0, 0, 1, 8'h80, 7,    8'h00}); // 5 RST clear, reloaded FE
    vecs.push_back('{0, 0, 0, 0, 8'h00, 1,    8'hC0}); // 6 second period
    vecs.push_back('{1, 0, 1, 0, 8'hFF, 0,    8'h00}); // 7 TL2=FF
    vecs.push_back('{0, 0, 0, 1, 8'h02, 15,   8'h00}); // 8 start T2
    vecs.push_back('{0, 0, 0, 0, 8'h00, 1,    8'hA0}); // 9 FT2 at 16 clk_en
    vecs.push_back('{0, 0, 0, 1, 8'h80, 0,    8'h00}); // 10 RST clear
    vecs.push_back('{0, 0, 0, 0, 8'h00, 15,   8'h00}); // 11 still running
    vecs.push_back('{0, 0, 0, 0, 8'h00, 1,    8'hA0}); // 12 FT2 re-sets
    vecs.push_back('{1, 1, 0, 0, 8'hFF, 0,    8'h00}); // 13 TL1=FF
    vecs.push_back('{0, 0, 0, 1, 8'h41, 12,   8'h00}); // 14 masked, 3 overflows
    vecs.push_back('{0, 0, 0, 1, 8'h01, 3,    8'h00}); // 15 unmask, no restart
    vecs.push_back('{0, 0, 0, 0, 8'h00, 1,    8'hC0}); // 16 next overflow sets
    vecs.push_back('{0, 0, 0, 1, 8'h41, 0,    8'h00}); // 17 mask write clears FT1
    vecs.push_back('{1, 1, 0, 0, 8'h00, 0,    8'h00}); // 18 TL1=00
    vecs.push_back('{0, 0, 0, 1, 8'h01, 1023, 8'h00}); // 19 255 ticks + 3
    vecs.push_back('{0, 0, 0, 0, 8'h00, 1,    8'hC0}); // 20 256th tick
    vecs.push_back('{1, 1, 1, 0, 8'hFF, 0,    8'h00}); // 21 TL1=TL2=FF together
    vecs.push_back('{0, 0, 0, 1, 8'h03, 4,    8'hC0}); // 22 T1 overflow
    vecs.push_back('{0, 0, 0, 0, 8'h00, 12,   8'hE0}); // 23 T2 overflow too

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].t1 || vecs[i].t2 || vecs[i].c)
        drive(1'b0, vecs[i].t1, vecs[i].t2, vecs[i].c, vecs[i].d);
      pulse_en(vecs[i].n_en);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // RST write on the overflow edge, then mask write on the overflow edge.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    pulse_en(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h80);
    check("ovf_vs_rst", 8'hC0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
    check("rst_clear", 8'h00);
    pulse_en(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h41);
    check("ovf_vs_mask", 8'hC0);

    // Start on a tick edge: reload wins and the tick is dropped.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    pulse_en(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    check("start_on_tick", 8'h00);
    pulse_en(3);
    check("start_tick_7", 8'h00);
    pulse_en(1);
    check("start_tick_8", 8'hC0);

    // TL write coinciding with start reload: reload takes old TL (FE).
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFE);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h01);
    pulse_en(7);
    check("tl_vs_reload_7", 8'h00);
    pulse_en(1);
    check("tl_vs_reload_8", 8'hC0);

    // Stop at count 0x80, restart: counter reloads TL=7E (130 ticks to overflow).
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h7E);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    pulse_en(8);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    pulse_en(4);
    check("stopped", 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    pulse_en(519);
    check("restart_519", 8'h00);
    pulse_en(1);
    check("restart_520", 8'hC0);

    // Reset mid-run returns everything to reset values and stops the timer.
    do_reset();
    check("midrun_reset", 8'h00);
    pulse_en(20);
    check("after_reset_idle", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
